// File: rtl/carpici_denetleyici.sv
// Two-requester front end for a shared combinational 32x32 signed multiplier:
// round-robin grant, multicycle settle, RISC-V M high/low word correction.
module carpici_denetleyici #(
    parameter int CARPIM_CEVRIM = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        istek0_gecerli_i,
    output logic        istek0_hazir_o,
    input  logic [31:0] istek0_islec0_i,
    input  logic [31:0] istek0_islec1_i,
    input  logic [1:0]  istek0_islem_i,
    input  logic        istek1_gecerli_i,
    output logic        istek1_hazir_o,
    input  logic [31:0] istek1_islec0_i,
    input  logic [31:0] istek1_islec1_i,
    input  logic [1:0]  istek1_islem_i,
    output logic [31:0] carpici_islec0_o,
    output logic [31:0] carpici_islec1_o,
    output logic        carpici_gecerli_o,
    input  logic [63:0] carpici_carpim_i,
    output logic        sonuc_gecerli_o,
    input  logic        sonuc_hazir_i,
    output logic [31:0] sonuc_o,
    output logic        sonuc_kimlik_o
);

    typedef enum logic [1:0] {BOS, BEKLE, SONUC} durum_t;

    localparam logic [3:0] SAYAC_BAS = 4'(CARPIM_CEVRIM - 1);

    durum_t      durum;
    logic [3:0]  sayac;
    logic        oncelik;
    logic [1:0]  islem_q;
    logic        kimlik_q;

    logic        secim;
    logic        istek_var;
    logic [31:0] sec_islec0;
    logic [31:0] sec_islec1;
    logic [1:0]  sec_islem;

    always_comb begin
        istek_var  = istek0_gecerli_i | istek1_gecerli_i;
        secim      = (istek0_gecerli_i & istek1_gecerli_i) ? oncelik : istek1_gecerli_i;
        sec_islec0 = secim ? istek1_islec0_i : istek0_islec0_i;
        sec_islec1 = secim ? istek1_islec1_i : istek0_islec1_i;
        sec_islem  = secim ? istek1_islem_i  : istek0_islem_i;
    end

    // Gated with reset so a requester held valid through reset sees no grant.
    assign istek0_hazir_o = rstn_i && (durum == BOS) && istek_var && !secim;
    assign istek1_hazir_o = rstn_i && (durum == BOS) && istek_var &&  secim;

    // The multiplier is signed x signed; unsigned operands need the other
    // operand added into the high word for each operand whose MSB is set.
    logic [31:0] ust;
    logic [31:0] ek_a;
    logic [31:0] ek_b;
    logic [31:0] duzeltilmis;

    always_comb begin
        ust  = carpici_carpim_i[63:32];
        ek_a = (islem_q[1] && carpici_islec1_o[31]) ? carpici_islec0_o : 32'd0;
        ek_b = (islem_q == 2'b11 && carpici_islec0_o[31]) ? carpici_islec1_o : 32'd0;
        case (islem_q)
            2'b00:   duzeltilmis = carpici_carpim_i[31:0];
            2'b01:   duzeltilmis = ust;
            default: duzeltilmis = ust + ek_a + ek_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum             <= BOS;
            sayac             <= 4'd0;
            oncelik           <= 1'b0;
            carpici_islec0_o  <= 32'd0;
            carpici_islec1_o  <= 32'd0;
            islem_q           <= 2'b00;
            kimlik_q          <= 1'b0;
            carpici_gecerli_o <= 1'b0;
            sonuc_gecerli_o   <= 1'b0;
            sonuc_o           <= 32'd0;
            sonuc_kimlik_o    <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (istek_var) begin
                        carpici_islec0_o  <= sec_islec0;
                        carpici_islec1_o  <= sec_islec1;
                        islem_q           <= sec_islem;
                        kimlik_q          <= secim;
                        oncelik           <= ~secim;
                        sayac             <= SAYAC_BAS;
                        carpici_gecerli_o <= 1'b1;
                        durum             <= BEKLE;
                    end
                end
                BEKLE: begin
                    if (sayac != 4'd0) begin
                        sayac <= sayac - 4'd1;
                    end else begin
                        sonuc_o           <= duzeltilmis;
                        sonuc_kimlik_o    <= kimlik_q;
                        carpici_gecerli_o <= 1'b0;
                        sonuc_gecerli_o   <= 1'b1;
                        durum             <= SONUC;
                    end
                end
                SONUC: begin
                    if (sonuc_hazir_i) begin
                        sonuc_gecerli_o <= 1'b0;
                        durum           <= BOS;
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_carpici_denetleyici.sv
// Randomized and directed bench for carpici_denetleyici; results are checked
// by a negedge scoreboard against a plain-arithmetic model of the M ops.
module tb_carpici_denetleyici;

    localparam int C = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        g[2];
    logic        hz[2];
    logic [31:0] x0[2];
    logic [31:0] x1[2];
    logic [1:0]  op[2];
    logic [31:0] ca, cb, so;
    logic [63:0] cp;
    logic        cg, sg, sk;
    logic        rdy = 1'b1;

    assign cp = $signed({{32{ca[31]}}, ca}) * $signed({{32{cb[31]}}, cb});

    carpici_denetleyici #(.CARPIM_CEVRIM(C)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .istek0_gecerli_i(g[0]), .istek0_hazir_o(hz[0]),
        .istek0_islec0_i(x0[0]), .istek0_islec1_i(x1[0]), .istek0_islem_i(op[0]),
        .istek1_gecerli_i(g[1]), .istek1_hazir_o(hz[1]),
        .istek1_islec0_i(x0[1]), .istek1_islec1_i(x1[1]), .istek1_islem_i(op[1]),
        .carpici_islec0_o(ca), .carpici_islec1_o(cb), .carpici_gecerli_o(cg),
        .carpici_carpim_i(cp),
        .sonuc_gecerli_o(sg), .sonuc_hazir_i(rdy), .sonuc_o(so), .sonuc_kimlik_o(sk)
    );

    // Second instance built with a one-cycle settle time.
    logic        e_g[2];
    logic        e_hz[2];
    logic [31:0] e_x0[2];
    logic [31:0] e_x1[2];
    logic [1:0]  e_op[2];
    logic [31:0] e_ca, e_cb, e_so;
    logic [63:0] e_cp;
    logic        e_cg, e_sg, e_sk;
    logic        e_rdy = 1'b1;

    assign e_cp = $signed({{32{e_ca[31]}}, e_ca}) * $signed({{32{e_cb[31]}}, e_cb});

    carpici_denetleyici #(.CARPIM_CEVRIM(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .istek0_gecerli_i(e_g[0]), .istek0_hazir_o(e_hz[0]),
        .istek0_islec0_i(e_x0[0]), .istek0_islec1_i(e_x1[0]), .istek0_islem_i(e_op[0]),
        .istek1_gecerli_i(e_g[1]), .istek1_hazir_o(e_hz[1]),
        .istek1_islec0_i(e_x0[1]), .istek1_islec1_i(e_x1[1]), .istek1_islem_i(e_op[1]),
        .carpici_islec0_o(e_ca), .carpici_islec1_o(e_cb), .carpici_gecerli_o(e_cg),
        .carpici_carpim_i(e_cp),
        .sonuc_gecerli_o(e_sg), .sonuc_hazir_i(e_rdy), .sonuc_o(e_so), .sonuc_kimlik_o(e_sk)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: true-precision products, high or low word taken directly.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] o);
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     w;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        case (o)
            2'b00, 2'b01: w = 64'(sa * sbv);
            2'b10:        w = 64'(sa * longint'(ub));
            default:      w = ua * ub;
        endcase
        return (o == 2'b00) ? w[31:0] : w[63:32];
    endfunction

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } beklenen_t;

    beklenen_t beklenen[$];
    logic      busy = 1'b0;
    logic      prio = 1'b0;
    int        cyc = 0;
    int        acc_cyc = 0;
    logic      logging = 1'b0;
    int        ids[$];
    int        accs[$];

    always @(negedge clk) begin
        logic [1:0] ehz;
        logic       gid;
        logic       evc, evs;
        beklenen_t  e;
        cyc++;
        if (!rstn) begin
            beklenen.delete();
            busy = 1'b0;
            prio = 1'b0;
        end else begin
            ehz = 2'b00;
            gid = (g[0] & g[1]) ? prio : g[1];
            if (!busy && (g[0] | g[1])) ehz[gid] = 1'b1;
            chk("hazir", 64'({hz[1], hz[0]}), 64'(ehz));
            evc = busy && (cyc > acc_cyc) && (cyc <= acc_cyc + C);
            evs = busy && (cyc > acc_cyc + C);
            chk("carpici_gecerli", 64'(cg), 64'(evc));
            chk("sonuc_gecerli", 64'(sg), 64'(evs));
            if (busy && beklenen.size() > 0) begin
                if (evc) chk("carpici_islec", {ca, cb}, {beklenen[0].a, beklenen[0].b});
                if (evs && sg) chk("sonuc", 64'({sk, so}), 64'({beklenen[0].id, beklenen[0].r}));
                if (evs && rdy) begin
                    void'(beklenen.pop_front());
                    busy = 1'b0;
                end
            end
            if (ehz != 2'b00) begin
                e.id = gid;
                e.a  = x0[gid];
                e.b  = x1[gid];
                e.r  = ref_res(x0[gid], x1[gid], op[gid]);
                beklenen.push_back(e);
                prio    = ~gid;
                busy    = 1'b1;
                acc_cyc = cyc;
                if (logging) begin
                    ids.push_back(int'(gid));
                    accs.push_back(cyc);
                end
            end
        end
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input int patience,
                         output logic ok, output int att);
        g[id]  = 1'b1;
        x0[id] = a;
        x1[id] = b;
        op[id] = o;
        ok     = 1'b0;
        att    = 0;
        for (int n = 0; n < patience && !ok; n++) begin
            @(negedge clk);
            ok = hz[id];
            att++;
            @(posedge clk);
            #1;
        end
        g[id] = 1'b0;
    endtask

    task automatic yonlu(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic [31:0] ev);
        logic ok, seen;
        int   att;
        seen = 1'b0;
        issue(id, a, b, o, 100, ok, att);
        chk("yonlu_kabul", 64'(ok), 64'd1);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (sg) begin
                seen = 1'b1;
                chk("yonlu_sonuc", 64'({sk, so}), 64'({id[0], ev}));
            end
        end
        chk("yonlu_gorundu", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    int done_cnt = 0;

    task automatic rand_req(input int id, input int n);
        logic ok;
        int   att;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(id, opnd(), opnd(), 2'($urandom_range(0, 3)), $urandom_range(1, 8), ok, att);
        end
        done_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic        ok, seen;
        int          att;
        logic [32:0] tut;
        for (int i = 0; i < 2; i++) begin
            g[i] = 0; x0[i] = 0; x1[i] = 0; op[i] = 0;
            e_g[i] = 0; e_x0[i] = 0; e_x1[i] = 0; e_op[i] = 0;
        end

        #2;
        chk("reset_cikislar", 64'({hz[1], hz[0], cg, sg, sk}), 64'd0);
        chk("reset_veri", {ca, so}, 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Fairness: both held valid, grants alternate starting at 0.
        rdy = 1'b1;
        logging = 1'b1;
        fork
            for (int k = 0; k < 4; k++) begin
                logic ok0; int a0;
                issue(0, opnd(), opnd(), 2'($urandom_range(0, 3)), 100, ok0, a0);
            end
            for (int k = 0; k < 4; k++) begin
                logic ok1; int a1;
                issue(1, opnd(), opnd(), 2'($urandom_range(0, 3)), 100, ok1, a1);
            end
        join
        logging = 1'b0;
        chk("adil_sayi", 64'(ids.size()), 64'd8);
        for (int i = 0; i < ids.size(); i++) chk("adil_sira", 64'(ids[i]), 64'(i % 2));
        for (int i = 1; i < accs.size(); i++) chk("adil_aralik", 64'(accs[i] - accs[i-1]), 64'(C + 2));
        repeat (6) @(posedge clk);
        #1;

        yonlu(0, 32'd7, 32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB);
        yonlu(1, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
        yonlu(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE);
        yonlu(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF);
        yonlu(1, 32'h8000_0000, 32'h0000_0002, 2'b11, 32'h0000_0001);

        // Backpressure: result held, no grants, multiplier idle.
        rdy = 1'b0;
        issue(0, 32'd5, 32'd6, 2'b00, 100, ok, att);
        chk("bp_kabul0", 64'(ok), 64'd1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = sg;
        end
        chk("bp_gorundu", 64'(seen), 64'd1);
        tut = {sk, so};
        @(posedge clk);
        #1;
        g[1] = 1'b1; x0[1] = 32'd3; x1[1] = 32'd9; op[1] = 2'b00;
        repeat (5) begin
            @(negedge clk);
            chk("bp_sabit", 64'({sk, so}), 64'(tut));
            chk("bp_hazir", 64'({hz[1], hz[0]}), 64'd0);
            chk("bp_carpici", 64'(cg), 64'd0);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        issue(1, 32'd3, 32'd9, 2'b00, 10, ok, att);
        chk("bp_kabul1", 64'(ok), 64'd1);
        chk("bp_sonraki_kabul", 64'(att), 64'd2);
        repeat (6) @(posedge clk);
        #1;

        // Randomized traffic with random downstream stalls and withdrawals.
        done_cnt = 0;
        fork
            rand_req(0, 40);
            rand_req(1, 40);
            while (done_cnt < 2) begin
                @(posedge clk);
                #1 rdy = 1'($urandom_range(0, 1));
            end
        join
        rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset during BEKLE drops the operation.
        issue(1, 32'd11, 32'd12, 2'b00, 100, ok, att);
        repeat (C + 2) @(posedge clk);
        #1;
        issue(0, 32'hFFFF_FFFF, 32'd3, 2'b00, 100, ok, att);
        chk("rst_kabul", 64'(ok), 64'd1);
        #2;
        g[0] = 1'b1; g[1] = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rst_ani_kontrol", 64'({hz[1], hz[0], cg, sg, sk}), 64'd0);
        chk("rst_ani_veri", {ca, cb}, 64'd0);
        chk("rst_ani_sonuc", 64'(so), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        ids.delete();
        accs.delete();
        logging = 1'b1;
        fork
            begin logic oa; int aa; issue(0, 32'd2, 32'd3, 2'b00, 100, oa, aa); end
            begin logic ob; int ab; issue(1, 32'd4, 32'd5, 2'b00, 100, ob, ab); end
        join
        logging = 1'b0;
        chk("rst_ilk_izin", 64'(ids.size() > 0 ? ids[0] : 9), 64'd0);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 100, ok, att);
        chk("rst_istek1_kabul", 64'(ok), 64'd1);
        repeat (6) @(posedge clk);
        #1;

        // One-cycle settle instance.
        e_g[1] = 1'b1; e_x0[1] = 32'hFFFF_FFFF; e_x1[1] = 32'd2; e_op[1] = 2'b11;
        e_rdy = 1'b0;
        @(negedge clk);
        chk("c1_hazir", 64'(e_hz[1]), 64'd1);
        @(posedge clk);
        #1 e_g[1] = 1'b0;
        @(negedge clk);
        chk("c1_bekle", 64'({e_cg, e_sg}), 64'b10);
        @(negedge clk);
        chk("c1_gecerli", 64'({e_cg, e_sg}), 64'b01);
        chk("c1_sonuc", 64'({e_sk, e_so}), 64'({1'b1, 32'h0000_0001}));
        @(posedge clk);
        #1;
        e_g[0] = 1'b1; e_x0[0] = 32'd9; e_x1[0] = 32'd9; e_op[0] = 2'b00;
        @(negedge clk);
        chk("c1_geri_cekme_hazir", 64'({e_hz[1], e_hz[0]}), 64'd0);
        @(posedge clk);
        #1;
        e_g[0] = 1'b0;
        e_rdy = 1'b1;
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("c1_islem_yok", 64'({e_cg, e_sg, e_hz[1], e_hz[0]}), 64'd0);
        end
        chk("c1_sonuc_korunur", 64'(e_so), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
